// File: rtl/aes_decrypt_sequencer_pkg.sv
// Shared definitions for the iterative AES decrypt sequencer: AES-128 defaults,
// FSM state encoding and GF(2^8) helpers used by the shared round unit.
package aes_decrypt_sequencer_pkg;

  localparam int AES_NR = 10;
  localparam int AES_NB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } seqState_t;

  // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse S-box computed rather than tabulated: undo the affine map, then
  // invert in GF(2^8) as b^254 (0 maps to 0 naturally).
  function automatic logic [7:0] invSbox(input logic [7:0] s);
    logic [7:0] b;
    logic [7:0] sq;
    logic [7:0] acc;
    b   = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    sq  = b;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gfMul(sq, sq);
      acc = gfMul(acc, sq);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_decrypt_sequencer_round.sv
// Combinational AES inverse round: InvShiftRows -> InvSubBytes -> AddRoundKey
// -> InvMixColumns, with the mix stage bypassed for the last round.
// Byte k of the block sits at bits [BW-1-8k -: 8]; state[r][c] is byte r+4c.
module aes_decrypt_sequencer_round
  import aes_decrypt_sequencer_pkg::*;
#(
  parameter int NB = AES_NB
) (
  input  logic [NB*32-1:0] stateIn,
  input  logic [NB*32-1:0] roundKey,
  input  logic             skipMix,
  output logic [NB*32-1:0] stateOut
);

  localparam int BW = NB * 32;

  logic [BW-1:0] shifted;
  logic [BW-1:0] subbed;
  logic [BW-1:0] keyed;
  logic [BW-1:0] mixed;

  for (genvar c = 0; c < NB; c++) begin : gCol
    for (genvar r = 0; r < 4; r++) begin : gRow
      localparam int HI  = BW - 1 - 8 * (r + 4 * c);
      localparam int SRC = BW - 1 - 8 * (r + 4 * ((c + NB - r) % NB));
      // row r rotates right by r columns
      assign shifted[HI -: 8] = stateIn[SRC -: 8];
      assign subbed[HI -: 8]  = invSbox(shifted[HI -: 8]);
    end

    localparam int CH = BW - 1 - 32 * c;
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = keyed[CH -: 32];
    assign mixed[CH -: 32] = {
      gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09),
      gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d),
      gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b),
      gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e)
    };
  end

  assign keyed    = subbed ^ roundKey;
  assign stateOut = skipMix ? keyed : mixed;

endmodule

// File: rtl/aes_decrypt_sequencer.sv
// Iterative AES inverse cipher: one shared round unit reused NR times per
// block, with a loadable round-key store and valid/ready on both sides.
module aes_decrypt_sequencer
  import aes_decrypt_sequencer_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int NB    = AES_NB,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rk_we,
  input  logic [IDX_W-1:0] rk_idx,
  input  logic [NB*32-1:0] rk_data,
  output logic             rk_err,
  output logic             keys_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NB*32-1:0] in_block,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NB*32-1:0] out_block,
  output logic             busy
);

  localparam int BW = NB * 32;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  seqState_t        state, nextState;
  logic [BW-1:0]    rk [NR+1];
  logic [NR:0]      keyMask, keyMaskNext;
  logic [IDX_W-1:0] rnd;
  logic [BW-1:0]    st;
  logic [BW-1:0]    roundOut;
  logic             keyWrOk;
  logic             accept;

  assign keyWrOk  = rk_we && (state == IDLE) && (rk_idx <= LAST_IDX);
  assign in_ready = (state == IDLE) && keys_ready;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // rnd is 0 in FINAL, so the same key read serves both round kinds
  aes_decrypt_sequencer_round #(.NB(NB)) uRound (
    .stateIn  (st),
    .roundKey (rk[rnd]),
    .skipMix  (state == FINAL),
    .stateOut (roundOut)
  );

  // mask of indices written since reset; keys_ready tracks the post-write mask
  always_comb begin
    keyMaskNext = keyMask;
    if (keyWrOk) keyMaskNext[rk_idx] = 1'b1;
  end

  // round-key array: not reset, validity lives entirely in keyMask
  always_ff @(posedge clk) begin
    if (keyWrOk) rk[rk_idx] <= rk_data;
  end

  // key bookkeeping and the rejected-write pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      keyMask    <= '0;
      keys_ready <= 1'b0;
      rk_err     <= 1'b0;
    end else begin
      keyMask    <= keyMaskNext;
      keys_ready <= &keyMaskNext;
      rk_err     <= rk_we && !keyWrOk;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // FSM next-state
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (accept) nextState = ROUND;
      ROUND:   if (rnd == ONE) nextState = FINAL;
      FINAL:   nextState = DONE;
      DONE:    if (out_valid && out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // datapath: state register, round counter, result register.
  // out_valid is raised from DONE one cycle after entry, so the result is
  // advertised from a settled register and the block slot is NR+3 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= '0;
      rnd       <= '0;
      out_block <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          st  <= in_block ^ rk[NR];
          rnd <= LAST_IDX - ONE;
        end
        ROUND: begin
          st <= roundOut;
          if (rnd != '0) rnd <= rnd - ONE;
        end
        FINAL: out_block <= roundOut;
        DONE:  out_valid <= !(out_valid && out_ready);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// Bench for aes_decrypt_sequencer: FIPS-197 vectors plus random blocks that
// are encrypted by a forward-cipher reference and must decrypt back.
module tb_aes_decrypt_sequencer;

  localparam int NR = 10;
  localparam int NB = 4;
  localparam int IDX_W = 4;

  logic             clk;
  logic             rst;
  logic             rk_we;
  logic [IDX_W-1:0] rk_idx;
  logic [127:0]     rk_data;
  logic             rk_err;
  logic             keys_ready;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_block;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_block;
  logic             busy;

  aes_decrypt_sequencer #(.NR(NR), .NB(NB), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .rk_we(rk_we), .rk_idx(rk_idx), .rk_data(rk_data),
    .rk_err(rk_err), .keys_ready(keys_ready), .in_valid(in_valid),
    .in_ready(in_ready), .in_block(in_block), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0;
  int nFails  = 0;
  int acceptCyc = 0;
  logic [7:0]   sbox [256];
  logic [127:0] rkey [NR+1];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---- reference model: forward AES-128 built from field arithmetic ----
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  task automatic buildSbox;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expandKey(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rkey[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rkey[0][127-8*k -: 8];
    for (int rd = 1; rd <= NR; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = sbox[s[r+4*((c+r)%4)]];
      if (rd < NR)
        for (int c = 0; c < 4; c++) begin
          logic [7:0] a0, a1, a2, a3;
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
          t[4*c+3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
        end
      for (int k = 0; k < 16; k++) s[k] = t[k] ^ rkey[rd][127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  // ---- stimulus helpers ----
  task automatic writeKey(input int idx, input logic [127:0] data);
    rk_we = 1'b1; rk_idx = IDX_W'(idx); rk_data = data;
    tick;
    rk_we = 1'b0;
  endtask

  task automatic loadKeys;
    for (int i = 0; i <= NR; i++) writeKey(i, rkey[i]);
  endtask

  task automatic offer(input logic [127:0] ct);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin tick; n++; end
    chk("offer in_ready", 128'(in_ready), 128'(1));
    in_block = ct; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    acceptCyc = cyc;
  endtask

  task automatic collect(input logic [127:0] exp, input int hold, input string tag);
    out_ready = (hold == 0);
    while (!out_valid && (cyc - acceptCyc) < 40) tick;
    chk({tag, " latency"}, 128'(cyc - acceptCyc), 128'(NR + 1));
    chk({tag, " data"}, out_block, exp);
    chk({tag, " busy"}, 128'(busy), 128'(1));
    for (int i = 0; i < hold; i++) begin
      tick;
      chk({tag, " hold valid"}, 128'(out_valid), 128'(1));
      chk({tag, " hold data"}, out_block, exp);
      chk({tag, " hold in_ready"}, 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick;
    chk({tag, " post valid"}, 128'(out_valid), 128'(0));
    chk({tag, " post in_ready"}, 128'(in_ready), 128'(1));
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int a1;
    rst = 1'b1; rk_we = 1'b0; rk_idx = '0; rk_data = '0;
    in_valid = 1'b0; in_block = '0; out_ready = 1'b0;
    buildSbox;
    tick; tick;
    rst = 1'b0;
    tick;
    chk("reset in_ready", 128'(in_ready), 128'(0));
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset out_block", out_block, 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset rk_err", 128'(rk_err), 128'(0));
    chk("reset keys_ready", 128'(keys_ready), 128'(0));

    // key gating
    expandKey(C1_KEY);
    for (int i = 0; i < NR; i++) writeKey(i, rkey[i]);
    chk("partial keys_ready", 128'(keys_ready), 128'(0));
    chk("partial in_ready", 128'(in_ready), 128'(0));
    writeKey(NR, rkey[NR]);
    chk("full keys_ready", 128'(keys_ready), 128'(1));
    chk("full in_ready", 128'(in_ready), 128'(1));

    // FIPS-197 C.1, then the same block under backpressure
    offer(C1_CT);
    collect(C1_PT, 0, "c1");
    offer(C1_CT);
    collect(C1_PT, 5, "c1 bp");

    // App.B back-to-back with out_ready held high
    expandKey(B_KEY);
    loadKeys;
    offer(B_CT);
    a1 = acceptCyc;
    collect(B_PT, 0, "b2b first");
    offer(B_CT);
    chk("b2b slot", 128'(acceptCyc - a1), 128'(NR + 3));
    collect(B_PT, 0, "b2b second");

    // key write while a block is in flight is rejected
    offer(B_CT);
    tick; tick; tick;
    writeKey(2, {$urandom, $urandom, $urandom, $urandom});
    chk("round wr rk_err", 128'(rk_err), 128'(1));
    tick;
    chk("round wr rk_err pulse", 128'(rk_err), 128'(0));
    collect(B_PT, 0, "round wr");

    // out-of-range index in IDLE
    writeKey(11, {$urandom, $urandom, $urandom, $urandom});
    chk("idx11 rk_err", 128'(rk_err), 128'(1));
    chk("idx11 keys_ready", 128'(keys_ready), 128'(1));
    tick;
    chk("idx11 rk_err pulse", 128'(rk_err), 128'(0));
    offer(B_CT);
    collect(B_PT, 0, "idx11 run");

    // random keys and plaintexts through the forward reference
    for (int it = 0; it < 4; it++) begin
      logic [127:0] pt;
      expandKey({$urandom, $urandom, $urandom, $urandom});
      loadKeys;
      pt = {$urandom, $urandom, $urandom, $urandom};
      offer(encrypt(pt));
      collect(pt, int'($urandom_range(0, 3)), $sformatf("rand%0d", it));
    end

    // reset with rnd=5 in flight
    expandKey(C1_KEY);
    loadKeys;
    offer(C1_CT);
    tick; tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst busy", 128'(busy), 128'(0));
    chk("midrst out_valid", 128'(out_valid), 128'(0));
    chk("midrst keys_ready", 128'(keys_ready), 128'(0));
    chk("midrst in_ready", 128'(in_ready), 128'(0));
    chk("midrst out_block", out_block, 128'(0));
    loadKeys;
    offer(C1_CT);
    collect(C1_PT, 0, "after rst");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
